rails_chain: RTL and testbench



---
 rtl/rails_pkg.sv | 21 ++
 rtl/rails_station.sv | 102 ++++++++++
 rtl/rails_chain.sv | 125 ++++++++++++
 tb/tb_rails_chain.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rails_pkg.sv
// Shared types and default sizing for the rails_chain stack-permutation checker.
package rails_pkg;

    localparam int unsigned DW    = 4;
    localparam int unsigned MAX_N = 15;
    localparam int unsigned N_ST  = 2;
    localparam int unsigned CW    = $clog2(MAX_N + 1);

    typedef enum logic [1:0] {
        S_NUM,
        S_LOAD,
        S_RUN,
        S_OUT
    } state_t;

    // Address width for a buffer of the given depth, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rails_station.sv
// One dead-end siding: target buffer, LIFO stack and done/ok flags.
// Input sequence comes from src_buf (identity for station 0, upstream targets otherwise).
module rails_station #(
    parameter int unsigned DW    = 4,
    parameter int unsigned MAX_N = 15,
    parameter int unsigned CW    = $clog2(MAX_N + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                load,
    input  logic [DW-1:0]       load_idx,
    input  logic [DW-1:0]       load_val,
    input  logic                step,
    input  logic [CW-1:0]       n,
    input  logic [MAX_N*DW-1:0] src_buf,
    output logic [MAX_N*DW-1:0] tgt_buf,
    output logic                fin_c,
    output logic                ok_c
);
    import rails_pkg::*;

    localparam int unsigned AW    = idx_w(MAX_N);
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [DW-1:0] tgt   [DEPTH];
    logic [DW-1:0] stack [DEPTH];
    logic [DW-1:0] src   [DEPTH];
    logic [CW-1:0] in_idx;
    logic [CW-1:0] out_idx;
    logic [CW-1:0] sp;
    logic          done;
    logic          ok;

    logic [DW-1:0] top_c;
    logic [DW-1:0] want_c;
    logic          pop_c;
    logic          more_c;
    logic          at_end_c;

    // Power-of-two array depth keeps every truncated index in range.
    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_src
        if (i < int'(MAX_N)) begin : g_live
            assign src[i] = src_buf[i*DW +: DW];
            assign tgt_buf[i*DW +: DW] = tgt[i];
        end else begin : g_pad
            assign src[i] = '0;
        end
    end

    assign top_c    = stack[AW'(sp - ONE)];
    assign want_c   = tgt[AW'(out_idx)];
    assign pop_c    = (sp != '0) && (top_c == want_c);
    assign more_c   = in_idx < n;
    assign at_end_c = out_idx == n;
    assign fin_c    = done | at_end_c | (~pop_c & ~more_c);
    assign ok_c     = done ? ok : at_end_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_idx  <= '0;
            out_idx <= '0;
            sp      <= '0;
            done    <= 1'b0;
            ok      <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tgt[i]   <= '0;
                stack[i] <= '0;
            end
        end else begin
            if (clear) begin
                in_idx  <= '0;
                out_idx <= '0;
                sp      <= '0;
                done    <= 1'b0;
                ok      <= 1'b0;
            end
            // Beats past MAX_N are consumed upstream but not stored.
            if (load && (load_idx < DW'(MAX_N))) begin
                tgt[AW'(load_idx)] <= load_val;
            end
            if (step && !done) begin
                if (at_end_c) begin
                    done <= 1'b1;
                    ok   <= 1'b1;
                end else if (pop_c) begin
                    sp      <= sp - ONE;
                    out_idx <= out_idx + ONE;
                end else if (more_c) begin
                    stack[AW'(sp)] <= src[AW'(in_idx)];
                    sp             <= sp + ONE;
                    in_idx         <= in_idx + ONE;
                end else begin
                    done <= 1'b1;
                    ok   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rails_chain.sv
// Chained rails checker: N_ST stations run in parallel; result[k] is the AND of ok[0..k].
// Keeps the legacy number/data/valid beat protocol.
module rails_chain #(
    parameter int unsigned DW    = rails_pkg::DW,
    parameter int unsigned MAX_N = rails_pkg::MAX_N,
    parameter int unsigned N_ST  = rails_pkg::N_ST
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DW-1:0]        number,
    input  logic [N_ST*DW-1:0]   data,
    output logic                 valid,
    output logic [N_ST-1:0]      result
);
    import rails_pkg::*;

    localparam int unsigned IW = $clog2(MAX_N + 1);
    localparam logic [DW-1:0] DONE_ONE = DW'(1);

    state_t        state;
    logic [DW-1:0] n_reg;
    logic [DW-1:0] beat;

    logic              clear_c;
    logic              load_c;
    logic              step_c;
    logic              over_c;
    logic [IW-1:0]     n_eff_c;
    logic [N_ST-1:0]   fin_c;
    logic [N_ST-1:0]   ok_c;
    logic [N_ST-1:0]   chain_c;
    logic [MAX_N*DW-1:0] ident;
    logic [MAX_N*DW-1:0] bufs [N_ST];

    for (genvar i = 0; i < int'(MAX_N); i++) begin : g_ident
        assign ident[i*DW +: DW] = DW'(i + 1);
    end

    assign clear_c = (state == S_NUM) && (number != '0);
    assign load_c  = state == S_LOAD;
    assign step_c  = state == S_RUN;
    assign over_c  = 32'(n_reg) > MAX_N;
    assign n_eff_c = over_c ? IW'(MAX_N) : IW'(n_reg);

    for (genvar k = 0; k < int'(N_ST); k++) begin : g_st
        logic [MAX_N*DW-1:0] src;
        if (k == 0) begin : g_first
            assign src = ident;
        end else begin : g_next
            assign src = bufs[k-1];
        end

        rails_station #(
            .DW    (DW),
            .MAX_N (MAX_N),
            .CW    (IW)
        ) u_station (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear_c),
            .load     (load_c),
            .load_idx (beat),
            .load_val (data[k*DW +: DW]),
            .step     (step_c),
            .n        (n_eff_c),
            .src_buf  (src),
            .tgt_buf  (bufs[k]),
            .fin_c    (fin_c[k]),
            .ok_c     (ok_c[k])
        );
    end

    // A downstream station only counts once every upstream station succeeded.
    always_comb begin
        logic acc;
        acc     = 1'b1;
        chain_c = '0;
        for (int k = 0; k < int'(N_ST); k++) begin
            acc        = acc & ok_c[k];
            chain_c[k] = acc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_NUM;
            n_reg  <= '0;
            beat   <= '0;
            valid  <= 1'b0;
            result <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_NUM: begin
                    if (number != '0) begin
                        n_reg <= number;
                        beat  <= '0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    beat <= beat + DONE_ONE;
                    if (beat == n_reg - DONE_ONE) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Stations finishing in this step are included, so S_RUN lasts at most 2N+1 cycles.
                    if (&fin_c) begin
                        valid  <= 1'b1;
                        result <= over_c ? '0 : chain_c;
                        state  <= S_OUT;
                    end
                end
                S_OUT: begin
                    state <= S_NUM;
                end
                default: begin
                    state <= S_NUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rails_chain.sv
// Scoreboard bench for rails_chain: default 2-station instance and a 3-station DW=5 instance.
module tb_rails_chain;

    typedef int pat_t [3][32];

    logic       clk = 1'b0;
    logic       reset_a, reset_b;
    logic [3:0] number_a;
    logic [7:0] data_a;
    logic       valid_a;
    logic [1:0] result_a;
    logic [4:0]  number_b;
    logic [14:0] data_b;
    logic        valid_b;
    logic [2:0]  result_b;

    int checks = 0;
    int errors = 0;
    int pushed_a = 0, pushed_b = 0;
    int pulses_a = 0, pulses_b = 0;
    logic [2:0] q_a [$];
    logic [2:0] q_b [$];

    always #5 clk = ~clk;

    rails_chain dut_a (
        .clk    (clk),
        .reset  (reset_a),
        .number (number_a),
        .data   (data_a),
        .valid  (valid_a),
        .result (result_a)
    );

    rails_chain #(.DW(5), .MAX_N(31), .N_ST(3)) dut_b (
        .clk    (clk),
        .reset  (reset_b),
        .number (number_b),
        .data   (data_b),
        .valid  (valid_b),
        .result (result_b)
    );

    // Monitors: pop one expectation per valid pulse.
    always @(negedge clk) begin : mon_a
        logic [2:0] e;
        if (valid_a) begin
            pulses_a++;
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL a_valid: unexpected valid, result=%b", result_a);
            end else begin
                e = q_a.pop_front();
                if (result_a !== e[1:0]) begin
                    errors++;
                    $display("FAIL a_result: got %b expected %b", result_a, e[1:0]);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [2:0] e;
        if (valid_b) begin
            pulses_b++;
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL b_valid: unexpected valid, result=%b", result_b);
            end else begin
                e = q_b.pop_front();
                if (result_b !== e) begin
                    errors++;
                    $display("FAIL b_result: got %b expected %b", result_b, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Stack-realisable iff the output is a permutation of the input avoiding the 3-1-2 pattern.
    function automatic bit stack_ok(input int n, input int in_seq[32], input int out_seq[32]);
        int  p[32];
        bit  used[32];
        bit  found;
        used = '{default: 1'b0};
        for (int j = 0; j < n; j++) begin
            found = 1'b0;
            for (int i = 0; i < n && !found; i++) begin
                if (in_seq[i] == out_seq[j]) begin
                    if (used[i]) return 1'b0;
                    used[i] = 1'b1;
                    p[j]    = i;
                    found   = 1'b1;
                end
            end
            if (!found) return 1'b0;
        end
        for (int a = 0; a < n; a++)
            for (int b = a + 1; b < n; b++)
                for (int c = b + 1; c < n; c++)
                    if (p[b] < p[c] && p[c] < p[a]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [2:0] model(input int n, input int nst, input pat_t v);
        int   in_seq[32];
        bit   all_ok;
        logic [2:0] res;
        res    = '0;
        all_ok = 1'b1;
        for (int k = 0; k < nst; k++) begin
            if (k == 0) begin
                in_seq = '{default: 0};
                for (int i = 0; i < n; i++) in_seq[i] = i + 1;
            end else begin
                in_seq = v[k-1];
            end
            all_ok = all_ok & stack_ok(n, in_seq, v[k]);
            res[k] = all_ok;
        end
        return res;
    endfunction

    function automatic void stack_perm(input int n, input int src[32], output int dst[32]);
        int stk[$];
        int i, o;
        i = 0;
        o = 0;
        dst = '{default: 0};
        while (o < n) begin
            if (i < n && (stk.size() == 0 || $urandom_range(1, 0) == 1)) begin
                stk.push_back(src[i]);
                i++;
            end else begin
                dst[o] = stk.pop_back();
                o++;
            end
        end
    endfunction

    function automatic void gen(output pat_t v, input int n, input int nst, input int vmax);
        int in_seq[32];
        int tmp[32];
        int m, j, t;
        v = '{default: '{default: 0}};
        for (int k = 0; k < nst; k++) begin
            if (k == 0) begin
                in_seq = '{default: 0};
                for (int i = 0; i < n; i++) in_seq[i] = i + 1;
            end else begin
                in_seq = v[k-1];
            end
            m = $urandom_range(9, 0);
            if (m < 7) begin
                stack_perm(n, in_seq, tmp);
            end else if (m < 9) begin
                tmp = in_seq;
                for (int i = 0; i < n; i++) begin
                    j = $urandom_range(n - 1, 0);
                    t = tmp[i]; tmp[i] = tmp[j]; tmp[j] = t;
                end
            end else begin
                tmp = '{default: 0};
                for (int i = 0; i < n; i++) tmp[i] = $urandom_range(vmax, 0);
            end
            v[k] = tmp;
        end
    endfunction

    // Two-station directed pattern, station sequences written as hex digits MSB first.
    function automatic void mk(output pat_t v, input int n, input int s0, input int s1);
        v = '{default: '{default: 0}};
        for (int i = 0; i < n; i++) begin
            v[0][i] = (s0 >> (4 * (n - 1 - i))) & 15;
            v[1][i] = (s1 >> (4 * (n - 1 - i))) & 15;
        end
    endfunction

    task automatic cyc(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    // Entered and left during an S_NUM cycle, 1 time unit after the edge.
    task automatic run_pattern(input int which, input int n, input pat_t v, input int nst,
                               input logic [2:0] exp);
        bit got;
        if (which == 0) number_a = 4'(n); else number_b = 5'(n);
        cyc(1);
        number_a = '0;
        number_b = '0;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < nst; k++) begin
                if (which == 0) data_a[k*4 +: 4] = 4'(v[k][i]);
                else            data_b[k*5 +: 5] = 5'(v[k][i]);
            end
            cyc(1);
        end
        if (which == 0) begin q_a.push_back(exp); pushed_a++; end
        else            begin q_b.push_back(exp); pushed_b++; end
        got = 1'b0;
        for (int j = 0; j < 2 * n + 2 && !got; j++) begin
            cyc(1);
            got = (which == 0) ? valid_a : valid_b;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL latency: dut %0d n=%0d no valid within %0d cycles", which, n, 2 * n + 2);
        end else begin
            cyc(1);
        end
    endtask

    initial begin
        pat_t v;
        int   n;
        reset_a  = 1'b1;
        reset_b  = 1'b1;
        number_a = '0;
        number_b = '0;
        data_a   = '0;
        data_b   = '0;
        cyc(3);
        chk("reset_valid_a", valid_a, 0);
        chk("reset_result_a", result_a, 0);
        chk("reset_valid_b", valid_b, 0);
        chk("reset_result_b", result_b, 0);
        reset_a = 1'b0;
        reset_b = 1'b0;

        mk(v, 5, 'h54321, 'h12345); run_pattern(0, 5, v, 2, 3'b011);
        cyc(3);
        chk("result_hold", result_a, 3);
        mk(v, 5, 'h54123, 'h12345); run_pattern(0, 5, v, 2, 3'b000);
        mk(v, 3, 'h123, 'h312);     run_pattern(0, 3, v, 2, 3'b001);
        mk(v, 1, 'h1, 'h1);         run_pattern(0, 1, v, 2, 3'b011);
        mk(v, 2, 'h21, 'h12);       run_pattern(0, 2, v, 2, 3'b011);
        mk(v, 3, 'h127, 'h123);     run_pattern(0, 3, v, 2, 3'b000);
        number_a = '0;
        cyc(4);
        mk(v, 2, 'h12, 'h21);       run_pattern(0, 2, v, 2, 3'b011);

        // Abort during the third load beat.
        number_a = 4'd5;
        cyc(1);
        number_a = '0;
        data_a = 8'h15; cyc(1);
        data_a = 8'h24; cyc(1);
        data_a = 8'h33; reset_a = 1'b1; cyc(1);
        reset_a = 1'b0;
        chk("abort_result", result_a, 0);
        chk("abort_valid", valid_a, 0);
        cyc(8);
        chk("abort_no_pulse", pulses_a, pushed_a);
        mk(v, 2, 'h12, 'h21);       run_pattern(0, 2, v, 2, 3'b011);

        for (int r = 0; r < 30; r++) begin
            n = $urandom_range(15, 1);
            gen(v, n, 2, 15);
            run_pattern(0, n, v, 2, model(n, 2, v));
        end

        v = '{default: '{default: 0}};
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 31; i++) v[k][i] = i + 1;
        run_pattern(1, 31, v, 3, 3'b111);
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(31, 1);
            gen(v, n, 3, 31);
            run_pattern(1, n, v, 3, model(n, 3, v));
        end

        cyc(5);
        chk("queue_a_empty", q_a.size(), 0);
        chk("queue_b_empty", q_b.size(), 0);
        chk("pulses_a", pulses_a, pushed_a);
        chk("pulses_b", pulses_b, pushed_b);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
